// File: rtl/audio_feed_i2c_target_if.sv
// I2C bus wires as seen by the audio_feed register target.
// SDA is open-drain, so the target only asserts sda_oe and never drives a level.
interface audio_feed_i2c_target_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/audio_feed_i2c_target.sv
// I2C target exposing a byte-wide register bank: write [dev][ptr][data...], read [dev][data...].
// 7-bit addressing, no clock stretching; bus lines are oversampled by clk.
module audio_feed_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         NREGS    = 16,
  parameter int         PTR_W    = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  audio_feed_i2c_target_if.slave  bus,
  output logic [8*NREGS-1:0]      regs_out,
  output logic                    wr_stb,
  output logic [PTR_W-1:0]        wr_ptr,
  output logic                    busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK
  } state_t;

  state_t           state;
  logic             scl_s1, scl_s2, scl_d;
  logic             sda_s1, sda_s2, sda_d;
  logic [3:0]       cnt;
  logic [6:0]       sr;
  logic [6:0]       tx;
  logic             rw;
  logic             ack_on;
  logic [PTR_W-1:0] ptr;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;
  logic [7:0] cur_reg;

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign rx_byte   = {sr, sda_s2};
  assign cur_reg   = regs_out[{ptr, 3'b000} +: 8];

  // Bus line synchronisers plus one history stage; idle bus level is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_d} <= {bus.scl_in, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_d} <= {bus.sda_in, sda_s1, sda_s2};
    end
  end

  // Protocol FSM; ack states drive low on the first scl fall and release on the second.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      sr       <= 7'd0;
      tx       <= 7'd0;
      rw       <= 1'b0;
      ack_on   <= 1'b0;
      ptr      <= '0;
      bus.sda_oe <= 1'b0;
      busy     <= 1'b0;
      wr_stb   <= 1'b0;
      wr_ptr   <= '0;
      regs_out <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (start_det) begin
        state      <= ADDR;
        cnt        <= 4'd0;
        ack_on     <= 1'b0;
        bus.sda_oe <= 1'b0;
        busy       <= 1'b1;
      end else if (stop_det) begin
        state      <= IDLE;
        ack_on     <= 1'b0;
        bus.sda_oe <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= 4'd0;
          end
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              sr  <= rx_byte[6:0];
              cnt <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                cnt <= 4'd0;
                if (state == ADDR) begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    rw    <= rx_byte[0];
                    state <= ADDR_ACK;
                  end else begin
                    bus.sda_oe <= 1'b0;
                    state      <= IDLE;
                  end
                end else if (state == PTR) begin
                  ptr   <= rx_byte[PTR_W-1:0];
                  state <= PTR_ACK;
                end else begin
                  regs_out[{ptr, 3'b000} +: 8] <= rx_byte;
                  wr_stb <= 1'b1;
                  wr_ptr <= ptr;
                  ptr    <= ptr + PTR_W'(1);
                  state  <= WACK;
                end
              end
            end
          end
          ADDR_ACK, PTR_ACK, WACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                ack_on     <= 1'b1;
                bus.sda_oe <= 1'b1;
              end else begin
                ack_on <= 1'b0;
                cnt    <= 4'd0;
                if (state == ADDR_ACK && rw) begin
                  tx         <= cur_reg[6:0];
                  bus.sda_oe <= ~cur_reg[7];
                  state      <= RDATA;
                end else if (state == ADDR_ACK) begin
                  bus.sda_oe <= 1'b0;
                  state      <= PTR;
                end else begin
                  bus.sda_oe <= 1'b0;
                  state      <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            // cnt counts rises; each fall presents the next bit, the 8th fall hands over the ack slot.
            if (scl_rise) begin
              cnt <= cnt + 4'd1;
            end else if (scl_fall) begin
              if (cnt == 4'd8) begin
                cnt        <= 4'd0;
                bus.sda_oe <= 1'b0;
                ptr        <= ptr + PTR_W'(1);
                state      <= RACK;
              end else begin
                bus.sda_oe <= ~tx[6];
                tx         <= {tx[5:0], 1'b0};
              end
            end
          end
          RACK: begin
            if (scl_rise) begin
              if (sda_s2) begin
                state <= IDLE;
              end else begin
                ack_on <= 1'b1;
              end
            end else if (scl_fall && ack_on) begin
              ack_on     <= 1'b0;
              tx         <= cur_reg[6:0];
              bus.sda_oe <= ~cur_reg[7];
              state      <= RDATA;
            end
          end
          default: begin
            bus.sda_oe <= 1'b0;
            state      <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_feed_i2c_target.sv
// Bit-banged I2C master driving audio_feed_i2c_target, checked against an array model
// of the register bank and pointer.
module tb_audio_feed_i2c_target;
  localparam int NREGS = 16;
  localparam int QT    = 50;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic [8*NREGS-1:0] regs_out;
  logic               wr_stb;
  logic [3:0]         wr_ptr;
  logic               busy;

  audio_feed_i2c_target_if bus();
  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  audio_feed_i2c_target dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .regs_out (regs_out),
    .wr_stb   (wr_stb),
    .wr_ptr   (wr_ptr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] mregs [NREGS];
  int mptr;
  int stb_q[$];
  int exp_q[$];
  logic [7:0] wbuf [8];

  always @(negedge clk) if (wr_stb === 1'b1) stb_q.push_back(int'(wr_ptr));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int i = 0; i < NREGS; i++) f[8*i +: 8] = mregs[i];
    return f;
  endfunction

  task automatic check_stb(input string tag);
    check({tag, " stb count"}, stb_q.size(), exp_q.size());
    for (int i = 0; i < stb_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s wr_ptr[%0d]", tag, i), stb_q[i], exp_q[i]);
    stb_q.delete();
    exp_q.delete();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; #QT; m_scl = 1'b1; #QT; m_sda = 1'b0; #QT; m_scl = 1'b0; #QT;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #QT; m_scl = 1'b1; #QT; m_sda = 1'b1; #QT;
  endtask

  task automatic wbit(input logic b);
    m_sda = b; #QT; m_scl = 1'b1; #(2*QT); m_scl = 1'b0; #QT;
  endtask

  task automatic rbit(output logic b);
    m_sda = 1'b1; #QT; m_scl = 1'b1; #QT; b = bus.sda_in; #QT; m_scl = 1'b0; #QT;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(b);
    acked = ~b;
  endtask

  task automatic rbyte(output logic [7:0] d, input logic master_ack);
    for (int i = 7; i >= 0; i--) rbit(d[i]);
    wbit(~master_ack);
  endtask

  task automatic do_write(input logic [7:0] p, input int n, input string tag);
    logic a;
    i2c_start();
    check({tag, " busy"}, busy, 1'b1);
    wbyte(8'h34, a); check({tag, " addr ack"}, a, 1'b1);
    wbyte(p, a);     check({tag, " ptr ack"}, a, 1'b1);
    mptr = p % NREGS;
    for (int i = 0; i < n; i++) begin
      wbyte(wbuf[i], a);
      check($sformatf("%s data ack %0d", tag, i), a, 1'b1);
      mregs[mptr] = wbuf[i];
      exp_q.push_back(mptr);
      mptr = (mptr + 1) % NREGS;
    end
    i2c_stop();
    #QT;
    check({tag, " busy after stop"}, busy, 1'b0);
    check({tag, " regs"}, regs_out, model_flat());
    check_stb(tag);
  endtask

  task automatic do_read(input logic [7:0] p, input int n, input string tag);
    logic a;
    logic [7:0] d;
    i2c_start();
    wbyte(8'h34, a); check({tag, " addr ack"}, a, 1'b1);
    wbyte(p, a);     check({tag, " ptr ack"}, a, 1'b1);
    mptr = p % NREGS;
    i2c_start();
    wbyte(8'h35, a); check({tag, " raddr ack"}, a, 1'b1);
    for (int i = 0; i < n; i++) begin
      rbyte(d, i < n - 1);
      check($sformatf("%s rdata %0d", tag, i), d, mregs[mptr]);
      mptr = (mptr + 1) % NREGS;
    end
    check({tag, " released after nack"}, bus.sda_oe, 1'b0);
    i2c_stop();
    #QT;
    check({tag, " busy after stop"}, busy, 1'b0);
    check_stb(tag);
  endtask

  initial begin
    logic a;
    int n;
    logic [7:0] p;
    for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
    mptr = 0;
    #22;
    #100 reset_n = 1'b1;
    #QT;
    check("reset sda_oe", bus.sda_oe, 1'b0);
    check("reset regs", regs_out, 128'd0);
    check("reset wr_stb", wr_stb, 1'b0);
    check("reset wr_ptr", wr_ptr, 4'd0);
    check("reset busy", busy, 1'b0);

    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    do_write(8'h03, 2, "wr basic");
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(8'h0F, 2, "wr wrap");
    do_read(8'h02, 3, "rd basic");

    i2c_start();
    wbyte(8'h36, a); check("wrong addr ack", a, 1'b0);
    check("wrong addr busy", busy, 1'b1);
    wbyte(8'h77, a); check("wrong addr data ack", a, 1'b0);
    i2c_stop();
    #QT;
    check("wrong addr regs", regs_out, model_flat());
    check_stb("wrong addr");

    i2c_start();
    wbyte(8'h34, a); check("abort addr ack", a, 1'b1);
    wbyte(8'h05, a); check("abort ptr ack", a, 1'b1);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
    i2c_stop();
    #QT;
    check("abort busy", busy, 1'b0);
    check("abort regs", regs_out, model_flat());
    check_stb("abort");
    wbuf[0] = 8'hC3;
    do_write(8'h05, 1, "after abort");

    for (int k = 0; k < 6; k++) begin
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
      do_write(p, n, $sformatf("rnd wr %0d", k));
      do_read(8'($urandom_range(0, 255)), $urandom_range(1, 4), $sformatf("rnd rd %0d", k));
    end

    wbuf[0] = 8'h3C;
    do_write(8'h07, 1, "pre reset");
    i2c_start();
    wbyte(8'h34, a);
    wbyte(8'h07, a);
    i2c_start();
    wbyte(8'h35, a);
    check("rdata drives zero", bus.sda_oe, 1'b1);
    reset_n = 1'b0;
    #1;
    check("reset mid sda_oe", bus.sda_oe, 1'b0);
    check("reset mid regs", regs_out, 128'd0);
    check("reset mid busy", busy, 1'b0);
    for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
    mptr = 0;
    m_sda = 1'b1; #QT; m_scl = 1'b1; #QT;
    reset_n = 1'b1;
    #(2*QT);
    do_read(8'h07, 1, "post reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
